// File: rtl/axis_fifo_pack.sv
// axis_fifo_pack
//
// AXI-Stream packing FIFO. Up to RATIO narrow input beats are gathered into
// one wide word and committed to an internal dual-port RAM. A beat with
// write_tlast flushes a partially filled word; unused upper lanes are written
// as zero (data, keep and user). The read side is first-word-fall-through
// with one word per cycle sustained throughput.
//
// Ports
//   aclk, resetn            clock (rising edge), synchronous active-low reset
//   write_tdata/tkeep/tuser narrow slave beat payload
//   write_tvalid/tlast      slave valid / end of packet
//   write_tready            slave ready (low only while full)
//   read_tdata/tkeep/tuser  packed word, lane k at [k*W +: W] (same for keep/user)
//   read_tvalid/tlast       master valid / word ends a packet
//   read_tready             master ready
//   count                   committed words currently stored
//   almost_full             count >= ALMOST_FULL

module axis_fifo_pack #(
  parameter int unsigned AXIS_DATA_WIDTH  = 512,
  parameter int unsigned AXIS_TUSER_WIDTH = 256,
  parameter int unsigned RATIO            = 2,
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned ALMOST_FULL      = (1 << ADDR_WIDTH) - 2
) (
  input  logic                                  aclk,
  input  logic                                  resetn,

  input  logic [AXIS_DATA_WIDTH-1:0]            write_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]          write_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]           write_tuser,
  input  logic                                  write_tvalid,
  input  logic                                  write_tlast,
  output logic                                  write_tready,

  output logic [RATIO*AXIS_DATA_WIDTH-1:0]      read_tdata,
  output logic [RATIO*AXIS_DATA_WIDTH/8-1:0]    read_tkeep,
  output logic [RATIO*AXIS_TUSER_WIDTH-1:0]     read_tuser,
  output logic                                  read_tvalid,
  output logic                                  read_tlast,
  input  logic                                  read_tready,

  output logic [ADDR_WIDTH:0]                   count,
  output logic                                  almost_full
);

  localparam int unsigned W     = AXIS_DATA_WIDTH;
  localparam int unsigned KW    = AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW    = AXIS_TUSER_WIDTH;
  localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned SL    = (RATIO > 1) ? RATIO - 1 : 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  // Pointer state
  ptr_t write_ptr;
  ptr_t write_ptr_d;
  ptr_t read_ptr;
  ptr_t next_read_ptr;

  // Lane accumulation
  logic [LW-1:0]   lane;
  logic [SL*W-1:0]  stage_data;
  logic [SL*KW-1:0] stage_keep;
  logic [SL*UW-1:0] stage_user;

  // Assembled word presented to the RAM write port
  logic [RATIO*W-1:0]  word_data;
  logic [RATIO*KW-1:0] word_keep;
  logic [RATIO*UW-1:0] word_user;

  // Storage
  logic [RATIO*W-1:0]  ram_data [DEPTH];
  logic [RATIO*KW-1:0] ram_keep [DEPTH];
  logic [RATIO*UW-1:0] ram_user [DEPTH];
  logic                ram_last [DEPTH];

  logic full;
  logic empty_vis;
  logic accept;
  logic commit;
  logic pop;

  // Status derived only from registered pointers, so write_tready never
  // depends combinationally on read_tready.
  assign count        = write_ptr - read_ptr;
  assign full         = (count == {1'b1, {ADDR_WIDTH{1'b0}}});
  assign write_tready = ~full;
  assign almost_full  = (32'(count) >= ALMOST_FULL);

  // Visibility lags commits by one cycle so the registered read port never
  // samples an address in the same edge it is being written.
  assign empty_vis   = (read_ptr == write_ptr_d);
  assign read_tvalid = ~empty_vis;

  assign accept = write_tvalid & ~full;
  assign commit = accept & (write_tlast | (lane == LAST_LANE));
  assign pop    = read_tvalid & read_tready;

  assign next_read_ptr = pop ? read_ptr + ptr_t'(1) : read_ptr;

  // Lanes below the current one come from staging, the current lane takes
  // the incoming beat, lanes above stay zero. Staging above the current lane
  // may hold data from an earlier word and is deliberately never selected.
  always_comb begin
    word_data = '0;
    word_keep = '0;
    word_user = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (k < 32'(lane)) begin
        word_data[k*W  +: W]  = stage_data[k*W  +: W];
        word_keep[k*KW +: KW] = stage_keep[k*KW +: KW];
        word_user[k*UW +: UW] = stage_user[k*UW +: UW];
      end
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k == 32'(lane)) begin
        word_data[k*W  +: W]  = write_tdata;
        word_keep[k*KW +: KW] = write_tkeep;
        word_user[k*UW +: UW] = write_tuser;
      end
    end
  end

  // Staging capture for beats that do not complete a word
  always_ff @(posedge aclk) begin
    if (accept && !commit) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        if (k == 32'(lane)) begin
          stage_data[k*W  +: W]  <= write_tdata;
          stage_keep[k*KW +: KW] <= write_tkeep;
          stage_user[k*UW +: UW] <= write_tuser;
        end
      end
    end
  end

  // Pointers and lane counter
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      write_ptr   <= '0;
      write_ptr_d <= '0;
      read_ptr    <= '0;
      lane        <= '0;
    end else begin
      write_ptr_d <= write_ptr;
      read_ptr    <= next_read_ptr;
      if (commit) begin
        write_ptr <= write_ptr + ptr_t'(1);
        lane      <= '0;
      end else if (accept) begin
        lane <= lane + LW'(1);
      end
    end
  end

  // Dual-port RAM: write at write_ptr on commit; registered read addressed
  // by next_read_ptr, which gives fall-through with back-to-back pops.
  always_ff @(posedge aclk) begin
    if (commit) begin
      ram_data[write_ptr[ADDR_WIDTH-1:0]] <= word_data;
      ram_keep[write_ptr[ADDR_WIDTH-1:0]] <= word_keep;
      ram_user[write_ptr[ADDR_WIDTH-1:0]] <= word_user;
      ram_last[write_ptr[ADDR_WIDTH-1:0]] <= write_tlast;
    end
    read_tdata <= ram_data[next_read_ptr[ADDR_WIDTH-1:0]];
    read_tkeep <= ram_keep[next_read_ptr[ADDR_WIDTH-1:0]];
    read_tuser <= ram_user[next_read_ptr[ADDR_WIDTH-1:0]];
    read_tlast <= ram_last[next_read_ptr[ADDR_WIDTH-1:0]];
  end

endmodule

// File: tb/tb_axis_fifo_pack.sv
// Scoreboard bench for axis_fifo_pack: a RATIO=2 and a RATIO=4 instance
// share the narrow write payload but have separate valid/ready. Accepted
// beats feed a packing model that pushes expected words into per-instance
// queues; monitors pop and compare whenever a word is handed over.

module tb_axis_fifo_pack;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        resetn;
  logic [31:0] wdata;
  logic [3:0]  wkeep;
  logic [7:0]  wuser;
  logic        wlast;
  logic        v2, v4, wready2, wready4, rready2, rready4;

  logic [63:0]  rdata2;
  logic [7:0]   rkeep2;
  logic [15:0]  ruser2;
  logic         rvalid2, rlast2, af2;
  logic [2:0]   count2;

  logic [127:0] rdata4;
  logic [15:0]  rkeep4;
  logic [31:0]  ruser4;
  logic         rvalid4, rlast4, af4;
  logic [2:0]   count4;

  axis_fifo_pack #(.AXIS_DATA_WIDTH(32), .AXIS_TUSER_WIDTH(8), .RATIO(2),
                   .ADDR_WIDTH(2), .ALMOST_FULL(3)) u_dut2 (
    .aclk(aclk), .resetn(resetn),
    .write_tdata(wdata), .write_tkeep(wkeep), .write_tuser(wuser),
    .write_tvalid(v2), .write_tlast(wlast), .write_tready(wready2),
    .read_tdata(rdata2), .read_tkeep(rkeep2), .read_tuser(ruser2),
    .read_tvalid(rvalid2), .read_tlast(rlast2), .read_tready(rready2),
    .count(count2), .almost_full(af2));

  axis_fifo_pack #(.AXIS_DATA_WIDTH(32), .AXIS_TUSER_WIDTH(8), .RATIO(4),
                   .ADDR_WIDTH(2), .ALMOST_FULL(3)) u_dut4 (
    .aclk(aclk), .resetn(resetn),
    .write_tdata(wdata), .write_tkeep(wkeep), .write_tuser(wuser),
    .write_tvalid(v4), .write_tlast(wlast), .write_tready(wready4),
    .read_tdata(rdata4), .read_tkeep(rkeep4), .read_tuser(ruser4),
    .read_tvalid(rvalid4), .read_tlast(rlast4), .read_tready(rready4),
    .count(count4), .almost_full(af4));

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [7:0]  u;
  } beat_t;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic [31:0]  u;
    logic         l;
  } word_t;

  typedef beat_t beat_q_t[$];

  beat_t pb2[$], pb4[$];
  word_t q2[$], q4[$];

  int checks = 0;
  int passed = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [7:0] u);
    beat_t b;
    b.d = d;
    b.k = 4'hF;
    b.u = u;
    return b;
  endfunction

  function automatic beat_t rbeat();
    beat_t b;
    b.d = $urandom;
    b.k = 4'($urandom_range(0, 15));
    b.u = 8'($urandom_range(0, 255));
    return b;
  endfunction

  // Beat i of a word occupies lane i; lanes with no beat are all zero.
  function automatic word_t pack_word(input beat_q_t bs, input logic last);
    word_t w;
    w = '0;
    foreach (bs[i]) begin
      w.d[i*32 +: 32] = bs[i].d;
      w.k[i*4  +: 4]  = bs[i].k;
      w.u[i*8  +: 8]  = bs[i].u;
    end
    w.l = last;
    return w;
  endfunction

  task automatic model_accept(input int r, input beat_t b, input logic last);
    if (r == 2) begin
      pb2.push_back(b);
      if (last || pb2.size() == 2) begin
        q2.push_back(pack_word(pb2, last));
        pb2.delete();
      end
    end else begin
      pb4.push_back(b);
      if (last || pb4.size() == 4) begin
        q4.push_back(pack_word(pb4, last));
        pb4.delete();
      end
    end
  endtask

  task automatic model_reset();
    pb2.delete();
    pb4.delete();
    q2.delete();
    q4.delete();
  endtask

  // Called at posedge+1; ready is stable for the whole cycle.
  task automatic send(input int r, input beat_t b, input logic last);
    bit done = 1'b0;
    wdata = b.d;
    wkeep = b.k;
    wuser = b.u;
    wlast = last;
    if (r == 2) v2 = 1'b1; else v4 = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      if (((r == 2) ? wready2 : wready4) && resetn) begin
        model_accept(r, b, last);
        done = 1'b1;
      end
      @(posedge aclk); #1;
    end
    v2 = 1'b0;
    v4 = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL send_timeout r=%0d: beat %0h not accepted, required within 300 cycles", r, b.d);
    end
  endtask

  task automatic wait_drain(input int r);
    bit done = 1'b0;
    if (r == 2) rready2 = 1'b1; else rready4 = 1'b1;
    for (int t = 0; t < 2000 && !done; t++) begin
      if (r == 2) done = (q2.size() == 0) && !rvalid2;
      else        done = (q4.size() == 0) && !rvalid4;
      if (!done) begin @(posedge aclk); #1; end
    end
    if (!done) begin
      checks++;
      $display("FAIL drain_timeout r=%0d: words still pending, required empty within 2000 cycles", r);
    end
  endtask

  // Monitors: compare at negedge, before the edge where the handshake lands.
  initial begin : mon2
    logic [191:0] hv;
    bit held;
    word_t e;
    held = 1'b0;
    hv = '0;
    forever begin
      @(negedge aclk);
      if (!resetn) held = 1'b0;
      else begin
        if (held) begin
          chk("hold_valid2", {191'd0, rvalid2}, 192'd1);
          if (rvalid2) chk("hold_word2", {rdata2, rkeep2, ruser2, rlast2}, hv);
        end
        if (rvalid2 && rready2) begin
          if (q2.size() == 0) begin
            checks++;
            $display("FAIL pop_unexpected2: got word %0h, required no word pending", rdata2);
          end else begin
            e = q2.pop_front();
            chk("data2", rdata2, e.d);
            chk("keep2", rkeep2, e.k);
            chk("user2", ruser2, e.u);
            chk("last2", rlast2, e.l);
          end
        end
        held = rvalid2 && !rready2;
        hv = {rdata2, rkeep2, ruser2, rlast2};
      end
    end
  end

  initial begin : mon4
    logic [191:0] hv;
    bit held;
    word_t e;
    held = 1'b0;
    hv = '0;
    forever begin
      @(negedge aclk);
      if (!resetn) held = 1'b0;
      else begin
        if (held) begin
          chk("hold_valid4", {191'd0, rvalid4}, 192'd1);
          if (rvalid4) chk("hold_word4", {rdata4, rkeep4, ruser4, rlast4}, hv);
        end
        if (rvalid4 && rready4) begin
          if (q4.size() == 0) begin
            checks++;
            $display("FAIL pop_unexpected4: got word %0h, required no word pending", rdata4);
          end else begin
            e = q4.pop_front();
            chk("data4", rdata4, e.d);
            chk("keep4", rkeep4, e.k);
            chk("user4", ruser4, e.u);
            chk("last4", rlast4, e.l);
          end
        end
        held = rvalid4 && !rready4;
        hv = {rdata4, rkeep4, ruser4, rlast4};
      end
    end
  end

  // Random read backpressure during the random phases
  initial begin : rnd_ready
    forever begin
      @(posedge aclk); #1;
      if (rnd_rdy) begin
        rready2 = 1'($urandom_range(0, 1));
        rready4 = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int acc;
    resetn = 1'b0;
    v2 = 1'b0; v4 = 1'b0;
    rready2 = 1'b0; rready4 = 1'b0;
    wdata = '0; wkeep = '0; wuser = '0; wlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1'b1;
    model_reset();

    // Reset state
    chk("rst_count2", count2, 0);
    chk("rst_valid2", rvalid2, 0);
    chk("rst_ready2", wready2, 1);
    chk("rst_af2", af2, 0);
    chk("rst_count4", count4, 0);
    chk("rst_valid4", rvalid4, 0);

    // 4-beat packet -> two full words
    rready2 = 1'b1;
    for (int i = 0; i < 4; i++) send(2, mk(32'hA0 + 32'(i), 8'h10 + 8'(i)), i == 3);
    wait_drain(2);
    chk("drain_count_a", count2, 0);

    // 3-beat packet flush, then 1-beat packet
    for (int i = 0; i < 3; i++) send(2, mk(32'hB0 + 32'(i), 8'h20 + 8'(i)), i == 2);
    send(2, mk(32'hC0, 8'h30), 1'b1);
    wait_drain(2);

    // Fill to full with reads stalled
    rready2 = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      chk("fill_count", count2, q2.size());
      chk("fill_af", af2, (q2.size() >= 3) ? 1 : 0);
      wdata = 32'h50 + 32'(acc);
      wkeep = 4'hF;
      wuser = 8'h40 + 8'(acc);
      wlast = 1'b0;
      v2 = (acc < 10);
      if (v2 && wready2) begin
        model_accept(2, mk(wdata, wuser), 1'b0);
        acc++;
      end
      @(posedge aclk); #1;
    end
    v2 = 1'b0;
    chk("fill_accepted", acc, 8);
    chk("full_count", count2, 4);
    chk("full_ready", wready2, 0);
    chk("full_af", af2, 1);
    chk("full_valid", rvalid2, 1);

    // Single pop from full
    rready2 = 1'b1;
    chk("pop_cycle_ready", wready2, 0);
    @(posedge aclk); #1;
    rready2 = 1'b0;
    chk("after_pop_count", count2, 3);
    chk("after_pop_ready", wready2, 1);
    @(posedge aclk); #1;

    // Refill across the wrap while draining
    rready2 = 1'b1;
    for (int i = 0; i < 4; i++) send(2, mk(32'hF0 + 32'(i), 8'h60 + 8'(i)), i == 3);
    wait_drain(2);
    chk("wrap_count", count2, 0);

    // Reset in the middle of a packet
    send(2, mk(32'h1234_5678, 8'h77), 1'b0);
    resetn = 1'b0;
    model_reset();
    @(posedge aclk); #1;
    resetn = 1'b1;
    chk("midrst_count", count2, 0);
    chk("midrst_valid", rvalid2, 0);
    chk("midrst_ready", wready2, 1);
    send(2, mk(32'hD0, 8'h70), 1'b0);
    send(2, mk(32'hD1, 8'h71), 1'b0);
    wait_drain(2);

    // RATIO=4 directed 5-beat packet
    rready4 = 1'b1;
    for (int i = 0; i < 5; i++) send(4, mk(32'hE0 + 32'(i), 8'h80 + 8'(i)), i == 4);
    wait_drain(4);
    chk("r4_count", count4, 0);

    // Random traffic with random read backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
      send(4, rbeat(), $urandom_range(0, 4) == 0);
    end
    send(4, rbeat(), 1'b1);
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
      send(2, rbeat(), $urandom_range(0, 3) == 0);
    end
    send(2, rbeat(), 1'b1);
    rnd_rdy = 1'b0;
    @(posedge aclk); #1;
    wait_drain(4);
    wait_drain(2);
    chk("end_count4", count4, 0);
    chk("end_count2", count2, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
